// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between a fetch port (i_*) and a data port (d_*), one transaction in flight.
// Define ARB_RR_EN to alternate grants on conflict; otherwise the data port always wins.
module mem_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  // fetch port
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_kill,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  // memory bus
  output logic                bus_valid,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wstrb,
  input  logic                bus_ready,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]          r_state;
  logic                r_owner;   // 0 = fetch, 1 = data
  logic                r_drop;
  logic                r_bus_valid;
  logic                r_bus_we;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic [DATA_W/8-1:0] r_bus_wstrb;

  logic w_idle;
  logic w_i_ok;
  logic w_i_gnt;
  logic w_d_gnt;
  logic w_any_gnt;
  logic w_kill_own;

  assign w_idle     = (r_state == S_IDLE);
  assign w_i_ok     = i_req & ~i_kill;
  assign w_any_gnt  = w_i_gnt | w_d_gnt;
  assign w_kill_own = i_kill & ~r_owner;

`ifdef ARB_RR_EN
  logic r_last;   // last granted port, 0 = fetch

  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (w_idle) begin
      if (d_req && w_i_ok) begin
        w_d_gnt = ~r_last;
        w_i_gnt = r_last;
      end else begin
        w_d_gnt = d_req;
        w_i_gnt = w_i_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b0;
    end else if (w_any_gnt) begin
      r_last <= w_d_gnt;
    end
  end
`else
  assign w_d_gnt = w_idle & d_req;
  assign w_i_gnt = w_idle & w_i_ok & ~d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_owner     <= 1'b0;
      r_drop      <= 1'b0;
      r_bus_valid <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_wstrb <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_gnt) begin
            r_state     <= S_REQ;
            r_owner     <= w_d_gnt;
            r_drop      <= 1'b0;
            r_bus_valid <= 1'b1;
            r_bus_we    <= w_d_gnt & d_we;
            r_bus_addr  <= w_d_gnt ? d_addr  : i_addr;
            r_bus_wdata <= w_d_gnt ? d_wdata : '0;
            r_bus_wstrb <= w_d_gnt ? d_wstrb : '0;
          end
        end
        S_REQ: begin
          if (w_kill_own) r_drop <= 1'b1;
          if (r_bus_valid && bus_ready) begin
            r_bus_valid <= 1'b0;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          // a kill arriving with the response is too late to suppress it
          if (bus_rvalid) begin
            r_state <= S_IDLE;
            r_drop  <= 1'b0;
          end else if (w_kill_own) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i_gnt     = w_i_gnt;
  assign d_gnt     = w_d_gnt;
  assign d_rvalid  = (r_state == S_RESP) & bus_rvalid & r_owner;
  assign i_rvalid  = (r_state == S_RESP) & bus_rvalid & ~r_owner & ~r_drop;
  assign d_rdata   = bus_rdata;
  assign i_rdata   = bus_rdata;

  assign bus_valid = r_bus_valid;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_wstrb = r_bus_wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays the memory bus and scores responses.
// Conflict expectations follow ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req, i_kill, i_gnt, i_rvalid;
  logic [63:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_wstrb;
  logic        bus_valid, bus_we, bus_ready, bus_rvalid;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_kill(i_kill), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port_d;
    logic [63:0] data;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_err    = 0;
  int   n_checks = 0;
  bit   exp_d_seq [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare any response pulse against the oldest expected response.
  task automatic mon();
    exp_t e;
    if (i_rvalid === 1'b1 || d_rvalid === 1'b1) begin
      n_checks++;
      assert (sb.size() > 0) else begin
        n_err++;
        $error("FAIL rsp_spurious: observed i_rvalid=%0b d_rvalid=%0b expected no pulse", i_rvalid, d_rvalid);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_d_rvalid", {63'd0, d_rvalid}, {63'd0, e.port_d});
        chk("rsp_i_rvalid", {63'd0, i_rvalid}, {63'd0, !e.port_d});
        if (e.chk_data) chk("rsp_data", e.port_d ? d_rdata : i_rdata, e.data);
      end
    end
  endtask

  // Entered in the grant cycle; runs REQ (with stalls) and RESP, ends at the next IDLE negedge.
  task automatic bus_phase(input bit clr_i, input bit clr_d, input logic we,
                           input logic [63:0] addr, input logic [63:0] wdata, input logic [7:0] wstrb,
                           input int ready_wait, input int resp_wait, input int kill_at,
                           input logic [63:0] rdata);
    for (int k = 0; k <= ready_wait; k++) begin
      @(negedge clk);
      if (clr_i) begin i_req = 1'b0; i_addr = '1; end
      if (clr_d) begin d_req = 1'b0; d_addr = '1; d_wdata = '1; d_wstrb = '1; end
      i_kill     = (k == kill_at);
      bus_ready  = (k == ready_wait);
      bus_rvalid = (k < ready_wait);
      bus_rdata  = 64'hbad0 + 64'(k);
      #1;
      mon();
      chk("req_bus_valid", {63'd0, bus_valid}, 64'd1);
      chk("req_bus_we", {63'd0, bus_we}, {63'd0, we});
      chk("req_bus_addr", bus_addr, addr);
      if (we) begin
        chk("req_bus_wdata", bus_wdata, wdata);
        chk("req_bus_wstrb", {56'd0, bus_wstrb}, {56'd0, wstrb});
      end
      chk("req_i_gnt", {63'd0, i_gnt}, 64'd0);
      chk("req_d_gnt", {63'd0, d_gnt}, 64'd0);
    end
    for (int r = 0; r <= resp_wait; r++) begin
      @(negedge clk);
      i_kill     = 1'b0;
      bus_ready  = 1'b0;
      bus_rvalid = (r == resp_wait);
      bus_rdata  = (r == resp_wait) ? rdata : 64'hbad1;
      #1;
      mon();
      chk("resp_bus_valid", {63'd0, bus_valid}, 64'd0);
      chk("resp_i_gnt", {63'd0, i_gnt}, 64'd0);
      chk("resp_d_gnt", {63'd0, d_gnt}, 64'd0);
    end
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    i_kill     = 1'b0;
  endtask

  initial begin
`ifdef ARB_RR_EN
    exp_d_seq = '{1'b1, 1'b0, 1'b1};
`else
    exp_d_seq = '{1'b1, 1'b1, 1'b1};
`endif
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0; i_kill = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    // reset state
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_bus_valid", {63'd0, bus_valid}, 64'd0);
    chk("rst_bus_we", {63'd0, bus_we}, 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_bus_wdata", bus_wdata, 64'd0);
    chk("rst_bus_wstrb", {56'd0, bus_wstrb}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // fetch only
    @(negedge clk);
    i_req = 1'b1; i_addr = 64'h1000;
    #1;
    chk("f_i_gnt", {63'd0, i_gnt}, 64'd1);
    chk("f_d_gnt", {63'd0, d_gnt}, 64'd0);
    chk("f_bus_valid_c0", {63'd0, bus_valid}, 64'd0);
    sb.push_back('{1'b0, 64'hdead, 1'b1});
    bus_phase(1'b1, 1'b0, 1'b0, 64'h1000, 64'd0, 8'd0, 0, 0, -1, 64'hdead);
    #1;
    chk("f_idle_no_gnt", {63'd0, i_gnt | d_gnt}, 64'd0);

    // conflict: data first, fetch on the first IDLE cycle after the data response
    @(negedge clk);
    i_req = 1'b1; i_addr = 64'h1100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200;
    #1;
    chk("c1_d_gnt", {63'd0, d_gnt}, 64'd1);
    chk("c1_i_gnt", {63'd0, i_gnt}, 64'd0);
    sb.push_back('{1'b1, 64'h2222, 1'b1});
    bus_phase(1'b0, 1'b1, 1'b0, 64'h200, 64'd0, 8'd0, 0, 1, -1, 64'h2222);
    #1;
    chk("c1_i_gnt_after", {63'd0, i_gnt}, 64'd1);
    chk("c1_d_gnt_after", {63'd0, d_gnt}, 64'd0);
    sb.push_back('{1'b0, 64'h3333, 1'b1});
    bus_phase(1'b1, 1'b0, 1'b0, 64'h1100, 64'd0, 8'd0, 0, 0, -1, 64'h3333);

    // conflict with both ports requesting continuously
    i_req = 1'b1; i_addr = 64'h3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h4000;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("c2_d_gnt", {63'd0, d_gnt}, {63'd0, exp_d_seq[g]});
      chk("c2_i_gnt", {63'd0, i_gnt}, {63'd0, !exp_d_seq[g]});
      sb.push_back('{exp_d_seq[g], 64'h100 + 64'(g), 1'b1});
      bus_phase(1'b0, 1'b0, 1'b0, exp_d_seq[g] ? 64'h4000 : 64'h3000, 64'd0, 8'd0,
                g, 0, -1, 64'h100 + 64'(g));
    end
    i_req = 1'b0; d_req = 1'b0;
    #1;
    chk("c2_released", {63'd0, i_gnt | d_gnt}, 64'd0);

    // kill in IDLE blocks the fetch grant
    @(negedge clk);
    i_req = 1'b1; i_kill = 1'b1; i_addr = 64'h2000;
    #1;
    chk("kidle_i_gnt", {63'd0, i_gnt}, 64'd0);
    @(negedge clk);
    i_kill = 1'b0;
    #1;
    chk("k_i_gnt", {63'd0, i_gnt}, 64'd1);
    // killed in REQ: transaction completes, response dropped
    bus_phase(1'b1, 1'b0, 1'b0, 64'h2000, 64'd0, 8'd0, 1, 1, 0, 64'hbeef);
    i_req = 1'b1; i_addr = 64'h2008;
    #1;
    chk("k_next_i_gnt", {63'd0, i_gnt}, 64'd1);
    sb.push_back('{1'b0, 64'h5555, 1'b1});
    bus_phase(1'b1, 1'b0, 1'b0, 64'h2008, 64'd0, 8'd0, 0, 0, -1, 64'h5555);

    // backpressured store; a kill while data owns the bus has no effect
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h80; d_wdata = 64'hff; d_wstrb = 8'h0f;
    #1;
    chk("st_d_gnt", {63'd0, d_gnt}, 64'd1);
    sb.push_back('{1'b1, 64'd0, 1'b0});
    bus_phase(1'b0, 1'b1, 1'b1, 64'h80, 64'hff, 8'h0f, 5, 2, 2, 64'h0);
    d_we = 1'b0;

    // reset during RESP
    i_req = 1'b1; i_addr = 64'h3000;
    #1;
    chk("rr_i_gnt", {63'd0, i_gnt}, 64'd1);
    @(negedge clk);
    i_req = 1'b0; bus_ready = 1'b1;
    #1;
    chk("rr_bus_valid_req", {63'd0, bus_valid}, 64'd1);
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    chk("rr_bus_valid_resp", {63'd0, bus_valid}, 64'd0);
    #1 rst = 1'b0;
    bus_rvalid = 1'b1; bus_rdata = 64'h7777;
    #1;
    mon();
    chk("rr_i_rvalid", {63'd0, i_rvalid}, 64'd0);
    chk("rr_bus_valid", {63'd0, bus_valid}, 64'd0);
    chk("rr_bus_addr", bus_addr, 64'd0);
    @(negedge clk);
    rst = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    i_req = 1'b1; i_kill = 1'b1;
    #1;
    chk("rr_post_d_gnt", {63'd0, d_gnt}, 64'd1);
    chk("rr_post_i_gnt", {63'd0, i_gnt}, 64'd0);
    sb.push_back('{1'b1, 64'h1234, 1'b1});
    bus_phase(1'b1, 1'b1, 1'b0, 64'h40, 64'd0, 8'd0, 0, 0, -1, 64'h1234);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
